// File: rtl/kernel_pad.sv
// KxK causal kernel extractor with K-1 pointer-rotated row buffers and runtime
// border handling (crop, zero fill or edge replicate).
module kernel_pad #(
    parameter int KERNEL_SIZE    = 3,
    parameter int PIXEL_WIDTH    = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_COLS       = 1288,
    parameter int NUM_COLS_WIDTH = 11,
    parameter int DTYPE_WIDTH    = 8,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 'h01,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 'h04,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 'h08,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 'h10,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 'h20,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 'h80,
    parameter int HDR_NUM_COLS_ADDR = 0,
    parameter int HDR_NUM_ROWS_ADDR = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [1:0]                                    mode,
    input  logic                                          dvi,
    input  logic [DTYPE_WIDTH-1:0]                        dtypei,
    input  logic [DATA_WIDTH-1:0]                         datai,
    output logic                                          dvo,
    output logic [DTYPE_WIDTH-1:0]                        dtypeo,
    output logic [DATA_WIDTH-1:0]                         meta_datao,
    output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] kernel_datao,
    output logic                                          overflow
);
    localparam int K    = KERNEL_SIZE;
    localparam int NB   = K - 1;
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int KW   = $clog2(K);
    localparam int CNTW = $clog2(K);
    localparam int CW   = NUM_COLS_WIDTH + 1;
    localparam logic [CW-1:0]   MAX_ADDR = CW'(MAX_COLS);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(K - 1);

    typedef enum logic [1:0] {
        MODE_CROP = 2'd0,
        MODE_ZERO = 2'd1,
        MODE_REPL = 2'd2
    } mode_e;

    logic [PIXEL_WIDTH-1:0] mem_q [NB][MAX_COLS];
    logic [PIXEL_WIDTH-1:0] win_q [K][K];
    logic [PIXEL_WIDTH-1:0] rd    [K];

    logic [CNTW-1:0]        row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
    logic [CNTW-1:0]        vrow_q, vcol_q;
    logic [CW-1:0]          col_addr_q, col_addr_d;
    logic [BW-1:0]          wr_buf_q, wr_buf_d;
    logic [5:0]             hdr_addr_q, hdr_addr_d;
    mode_e                  mode_q, mode_d;
    logic                   dvo_q, dvo_d, ovf_q, ovf_d;
    logic [DTYPE_WIDTH-1:0] dtype_q;
    logic [DATA_WIDTH-1:0]  meta_q, meta_d;

    logic is_fs, is_rs, is_re, is_pix, is_hs, is_hdr, pix_wr;
    logic row_full, col_full, crop;
    logic [NUM_COLS_WIDTH-1:0] col_idx;
    int row_lo, col_lo, ri, cj;
    logic [PIXEL_WIDTH-1:0] tap;

    assign row_full = (row_cnt_q == CNT_MAX);
    assign col_full = (col_cnt_q == CNT_MAX);
    assign crop     = (mode_q == MODE_CROP);
    assign col_idx  = col_addr_q[NUM_COLS_WIDTH-1:0];
    assign pix_wr   = is_pix && (col_addr_q != MAX_ADDR);

    always_comb begin
        is_fs  = 1'b0;
        is_rs  = 1'b0;
        is_re  = 1'b0;
        is_pix = 1'b0;
        is_hs  = 1'b0;
        is_hdr = 1'b0;
        if (dvi && enable) begin
            if (dtypei == DTYPE_FRAME_START)                 is_fs  = 1'b1;
            else if (dtypei == DTYPE_ROW_START)              is_rs  = 1'b1;
            else if (dtypei == DTYPE_ROW_END)                is_re  = 1'b1;
            else if ((dtypei & DTYPE_PIXEL_MASK) != '0)      is_pix = 1'b1;
            else if (dtypei == DTYPE_HEADER_START)           is_hs  = 1'b1;
            else if (dtypei == DTYPE_HEADER)                 is_hdr = 1'b1;
        end
    end

    always_comb begin
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        col_addr_d = col_addr_q;
        wr_buf_d   = wr_buf_q;
        hdr_addr_d = hdr_addr_q;
        mode_d     = mode_q;
        if (!enable) begin
            row_cnt_d  = '0;
            col_cnt_d  = '0;
            col_addr_d = '0;
            wr_buf_d   = '0;
            hdr_addr_d = '0;
        end else if (is_fs) begin
            row_cnt_d = '0;
            case (mode)
                2'd1:    mode_d = MODE_ZERO;
                2'd2:    mode_d = MODE_REPL;
                default: mode_d = MODE_CROP;
            endcase
        end else if (is_rs) begin
            col_addr_d = '0;
            col_cnt_d  = '0;
        end else if (is_re) begin
            if (!row_full) row_cnt_d = row_cnt_q + 1'b1;
            wr_buf_d = (wr_buf_q == BW'(NB - 1)) ? '0 : wr_buf_q + 1'b1;
        end else if (pix_wr) begin
            col_addr_d = col_addr_q + 1'b1;
            if (!col_full) col_cnt_d = col_cnt_q + 1'b1;
        end else if (is_hs) begin
            hdr_addr_d = '0;
        end else if (is_hdr) begin
            hdr_addr_d = hdr_addr_q + 1'b1;
        end
    end

    always_comb begin
        dvo_d  = 1'b0;
        meta_d = meta_q;
        ovf_d  = ovf_q | (is_pix && !pix_wr);
        if (dvi) begin
            meta_d = datai;
            if (!enable)            dvo_d = 1'b1;
            else if (is_pix)        dvo_d = pix_wr && (!crop || (row_full && col_full));
            else if (is_rs || is_re) dvo_d = !crop || row_full;
            else                    dvo_d = 1'b1;
            if (is_hdr && crop && (hdr_addr_q == 6'(HDR_NUM_COLS_ADDR) ||
                                   hdr_addr_q == 6'(HDR_NUM_ROWS_ADDR)))
                meta_d = datai - DATA_WIDTH'(K - 1);
        end
    end

    // buf[wr_buf] holds the oldest row until it is overwritten, so tap row i
    // reads the buffer i steps ahead of the write pointer.
    always_comb begin
        for (int unsigned i = 0; i < NB; i++)
            rd[i] = mem_q[BW'((int'(wr_buf_q) + i) % NB)][col_idx];
        rd[K-1] = datai[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset && pix_wr)
            mem_q[wr_buf_q][col_idx] <= datai[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvo_q      <= 1'b0;
            dtype_q    <= '0;
            meta_q     <= '0;
            ovf_q      <= 1'b0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            col_addr_q <= '0;
            wr_buf_q   <= '0;
            hdr_addr_q <= '0;
            mode_q     <= MODE_CROP;
            vrow_q     <= '0;
            vcol_q     <= '0;
            for (int unsigned i = 0; i < K; i++)
                for (int unsigned j = 0; j < K; j++)
                    win_q[i][j] <= '0;
        end else begin
            dvo_q      <= dvo_d;
            meta_q     <= meta_d;
            ovf_q      <= ovf_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            col_addr_q <= col_addr_d;
            wr_buf_q   <= wr_buf_d;
            hdr_addr_q <= hdr_addr_d;
            mode_q     <= mode_d;
            if (dvi) dtype_q <= dtypei;
            if (pix_wr) begin
                vrow_q <= row_cnt_q;
                vcol_q <= col_cnt_q;
                for (int unsigned i = 0; i < K; i++) begin
                    for (int unsigned j = 0; j < K - 1; j++)
                        win_q[i][j] <= win_q[i][j+1];
                    win_q[i][K-1] <= rd[i];
                end
            end
        end
    end

    // Border fill works on the counts captured with the window contents.
    always_comb begin
        kernel_datao = '0;
        row_lo = (K - 1) - int'(vrow_q);
        col_lo = (K - 1) - int'(vcol_q);
        ri     = 0;
        cj     = 0;
        tap    = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                ri  = (int'(i) < row_lo) ? row_lo : int'(i);
                cj  = (int'(j) < col_lo) ? col_lo : int'(j);
                tap = win_q[i][j];
                case (mode_q)
                    MODE_ZERO: if (int'(i) < row_lo || int'(j) < col_lo) tap = '0;
                    MODE_REPL: tap = win_q[KW'(ri)][KW'(cj)];
                    default:   tap = win_q[i][j];
                endcase
                kernel_datao[(i*K+j)*PIXEL_WIDTH +: PIXEL_WIDTH] = tap;
            end
        end
    end

    assign dvo        = dvo_q;
    assign dtypeo     = dtype_q;
    assign meta_datao = meta_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_kernel_pad.sv
// Directed bench for kernel_pad: K=3 on a 4x4 frame (pixel = 10r+c+1) plus a
// MAX_COLS=8 instance for the row overflow path.
module tb_kernel_pad;
    localparam logic [7:0] FS = 8'h01, FE = 8'h02, RS = 8'h04, RE = 8'h08;
    localparam logic [7:0] HS = 8'h10, HD = 8'h20, HE = 8'h40, PX = 8'h80;

    logic        clk = 1'b0;
    logic        reset, enable, dvi;
    logic [1:0]  mode;
    logic [7:0]  dtypei;
    logic [15:0] datai;

    logic        dvo, overflow, dvo2, ovf2;
    logic [7:0]  dtypeo, dtypeo2;
    logic [15:0] meta_datao, meta2;
    logic [89:0] kernel_datao, kern2;

    int checks = 0;
    int errors = 0;

    logic [89:0] kq[$];
    logic [15:0] hq[$];
    int rs_n, re_n;

    always #5 clk = ~clk;

    kernel_pad #(
        .KERNEL_SIZE(3), .PIXEL_WIDTH(10), .DATA_WIDTH(16), .MAX_COLS(1288),
        .NUM_COLS_WIDTH(11), .DTYPE_WIDTH(8),
        .DTYPE_FRAME_START(FS), .DTYPE_ROW_START(RS), .DTYPE_ROW_END(RE),
        .DTYPE_HEADER_START(HS), .DTYPE_HEADER(HD), .DTYPE_PIXEL_MASK(PX)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dvi(dvi),
        .dtypei(dtypei), .datai(datai), .dvo(dvo), .dtypeo(dtypeo),
        .meta_datao(meta_datao), .kernel_datao(kernel_datao), .overflow(overflow)
    );

    kernel_pad #(
        .KERNEL_SIZE(3), .PIXEL_WIDTH(10), .DATA_WIDTH(16), .MAX_COLS(8),
        .NUM_COLS_WIDTH(3), .DTYPE_WIDTH(8),
        .DTYPE_FRAME_START(FS), .DTYPE_ROW_START(RS), .DTYPE_ROW_END(RE),
        .DTYPE_HEADER_START(HS), .DTYPE_HEADER(HD), .DTYPE_PIXEL_MASK(PX)
    ) u_ovf (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dvi(dvi),
        .dtypei(dtypei), .datai(datai), .dvo(dvo2), .dtypeo(dtypeo2),
        .meta_datao(meta2), .kernel_datao(kern2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [89:0] pk(input int t0, input int t1, input int t2,
                                       input int t3, input int t4, input int t5,
                                       input int t6, input int t7, input int t8);
        return {10'(t8), 10'(t7), 10'(t6), 10'(t5), 10'(t4),
                10'(t3), 10'(t2), 10'(t1), 10'(t0)};
    endfunction

    function automatic logic [89:0] kat(input int i);
        return (i < kq.size()) ? kq[i] : '1;
    endfunction

    function automatic logic [15:0] hat(input int i);
        return (i < hq.size()) ? hq[i] : '1;
    endfunction

    task automatic send(input logic [7:0] dt, input logic [15:0] d);
        dvi = 1'b1; dtypei = dt; datai = d;
        @(posedge clk); #1;
        if (dvo) begin
            if (dtypeo == PX)      kq.push_back(kernel_datao);
            else if (dtypeo == HD) hq.push_back(meta_datao);
            else if (dtypeo == RS) rs_n++;
            else if (dtypeo == RE) re_n++;
        end
    endtask

    task automatic idle();
        dvi = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [1:0] m0, input logic [1:0] m1);
        kq.delete(); hq.delete(); rs_n = 0; re_n = 0; mode = m0;
        send(FS, 16'd0); send(HS, 16'd0); send(HD, 16'd4); send(HD, 16'd4); send(HE, 16'd0);
        for (int r = 0; r < 4; r++) begin
            send(RS, 16'd0);
            if (r == 1) mode = m1;
            for (int c = 0; c < 4; c++) send(PX, 16'(10*r + c + 1));
            send(RE, 16'd0);
        end
        send(FE, 16'd0);
        idle();
    endtask

    task automatic check_crop(input string tag);
        check({tag, "_count"}, 128'(kq.size()), 128'(4));
        check({tag, "_k22"}, 128'(kat(0)), 128'(pk(1, 2, 3, 11, 12, 13, 21, 22, 23)));
        check({tag, "_k23"}, 128'(kat(1)), 128'(pk(2, 3, 4, 12, 13, 14, 22, 23, 24)));
        check({tag, "_k32"}, 128'(kat(2)), 128'(pk(11, 12, 13, 21, 22, 23, 31, 32, 33)));
        check({tag, "_k33"}, 128'(kat(3)), 128'(pk(12, 13, 14, 22, 23, 24, 32, 33, 34)));
        check({tag, "_hcols"}, 128'(hat(0)), 128'(2));
        check({tag, "_hrows"}, 128'(hat(1)), 128'(2));
        check({tag, "_rs"}, 128'(rs_n), 128'(2));
        check({tag, "_re"}, 128'(re_n), 128'(2));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 2'd0; dvi = 1'b0; dtypei = '0; datai = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dvo", 128'(dvo), 128'(0));
        check("rst_dtype", 128'(dtypeo), 128'(0));
        check("rst_meta", 128'(meta_datao), 128'(0));
        check("rst_kernel", 128'(kernel_datao), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        reset = 1'b0;

        frame(2'd0, 2'd0);
        check_crop("crop");
        check("idle_dvo", 128'(dvo), 128'(0));

        frame(2'd1, 2'd1);
        check("zero_count", 128'(kq.size()), 128'(16));
        check("zero_k00", 128'(kat(0)), 128'(pk(0, 0, 0, 0, 0, 0, 0, 0, 1)));
        check("zero_k02", 128'(kat(2)), 128'(pk(0, 0, 0, 0, 0, 0, 1, 2, 3)));
        check("zero_k11", 128'(kat(5)), 128'(pk(0, 0, 0, 0, 1, 2, 0, 11, 12)));
        check("zero_k33", 128'(kat(15)), 128'(pk(12, 13, 14, 22, 23, 24, 32, 33, 34)));
        check("zero_hcols", 128'(hat(0)), 128'(4));
        check("zero_hrows", 128'(hat(1)), 128'(4));
        check("zero_rs", 128'(rs_n), 128'(4));

        frame(2'd2, 2'd2);
        check("repl_count", 128'(kq.size()), 128'(16));
        check("repl_k00", 128'(kat(0)), 128'(pk(1, 1, 1, 1, 1, 1, 1, 1, 1)));
        check("repl_k11", 128'(kat(5)), 128'(pk(1, 1, 2, 1, 1, 2, 11, 11, 12)));
        check("repl_k20", 128'(kat(8)), 128'(pk(1, 1, 1, 11, 11, 11, 21, 21, 21)));
        check("repl_k33", 128'(kat(15)), 128'(pk(12, 13, 14, 22, 23, 24, 32, 33, 34)));

        frame(2'd1, 2'd0);
        check("midchg_count", 128'(kq.size()), 128'(16));
        check("midchg_k11", 128'(kat(5)), 128'(pk(0, 0, 0, 0, 1, 2, 0, 11, 12)));
        frame(2'd0, 2'd0);
        check_crop("after_chg");
        frame(2'd3, 2'd3);
        check("mode3_count", 128'(kq.size()), 128'(4));

        enable = 1'b0;
        send(PX, 16'h0155);
        check("dis_dvo", 128'(dvo), 128'(1));
        check("dis_dtype", 128'(dtypeo), 128'(PX));
        check("dis_meta", 128'(meta_datao), 128'(16'h0155));
        check("dis_taps", 128'(kernel_datao), 128'(pk(12, 13, 14, 22, 23, 24, 32, 33, 34)));
        send(HD, 16'd4);
        check("dis_hdr", 128'(meta_datao), 128'(4));
        idle();
        check("dis_idle_dvo", 128'(dvo), 128'(0));
        enable = 1'b1;
        frame(2'd0, 2'd0);
        check_crop("reen");

        reset = 1'b1; idle(); reset = 1'b0;
        mode = 2'd1;
        send(FS, 16'd0); send(RS, 16'd0);
        for (int c = 0; c < 10; c++) begin
            send(PX, 16'(c + 1));
            if (c == 7) begin
                check("ovf_p8_flag", 128'(ovf2), 128'(0));
                check("ovf_p8_dvo", 128'(dvo2), 128'(1));
            end
            if (c >= 8) begin
                check("ovf_flag", 128'(ovf2), 128'(1));
                check("ovf_dvo", 128'(dvo2), 128'(0));
            end
        end
        send(RE, 16'd0); send(RS, 16'd0);
        send(PX, 16'd11); send(PX, 16'd12);
        check("ovf_next_dvo", 128'(dvo2), 128'(1));
        check("ovf_next_k11", 128'(kern2), 128'(pk(0, 0, 0, 0, 1, 2, 0, 11, 12)));
        check("ovf_sticky", 128'(ovf2), 128'(1));
        send(RE, 16'd0); send(FE, 16'd0); idle();
        reset = 1'b1; idle(); reset = 1'b0;
        check("ovf_cleared", 128'(ovf2), 128'(0));

        mode = 2'd0;
        send(FS, 16'd0); send(HS, 16'd0); send(HD, 16'd4); send(HD, 16'd4); send(HE, 16'd0);
        for (int r = 0; r < 2; r++) begin
            send(RS, 16'd0);
            for (int c = 0; c < 4; c++) send(PX, 16'(10*r + c + 1));
            send(RE, 16'd0);
        end
        send(RS, 16'd0); send(PX, 16'd21); send(PX, 16'd22);
        reset = 1'b1;
        send(PX, 16'd23);
        check("mid_rst_dvo", 128'(dvo), 128'(0));
        check("mid_rst_dtype", 128'(dtypeo), 128'(0));
        check("mid_rst_meta", 128'(meta_datao), 128'(0));
        check("mid_rst_taps", 128'(kernel_datao), 128'(0));
        reset = 1'b0;
        idle();
        frame(2'd0, 2'd0);
        check_crop("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
